// File: rtl/edge_fsm_pkg.sv
// Shared state codes and edge-mode encodings for the multi-channel edge detector.
package edge_fsm_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_ROSE = 3'd3,
        S_FELL = 3'd4
    } state_t;

    localparam logic [1:0] M_ANY  = 2'b00;
    localparam logic [1:0] M_RISE = 2'b01;
    localparam logic [1:0] M_FALL = 2'b10;
    localparam logic [1:0] M_OFF  = 2'b11;

endpackage

// File: rtl/edge_fsm_channel.sv
// One channel: run-length glitch filter, five-state level/edge FSM,
// registered event pulse and saturating sticky event counter.
module edge_fsm_channel
    import edge_fsm_pkg::*;
#(
    parameter int MIN_RUN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             sample,
    input  logic [1:0]       mode,
    input  logic             clear_cnt,
    output logic             evt_next,
    output logic             evt,
    output logic             level,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [3:0]       RUN_MAX = 4'(MIN_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_next;
    logic             raw_prev;
    logic [3:0]       run_cnt, run_next;
    logic             acc, level_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    // NOTE: every signal gets its default first, so no path through this block can infer a latch.
    always_comb begin
        run_next   = run_cnt;
        level_next = level;
        state_next = state_q;
        evt_next   = 1'b0;
        cnt_next   = cnt;
        sat_next   = sat;
        acc        = 1'b0;

        if (valid) begin
            if (sample == raw_prev && run_cnt != 4'd0)
                run_next = (run_cnt < RUN_MAX) ? run_cnt + 4'd1 : RUN_MAX;
            else
                run_next = 4'd1;
            acc = (run_next == RUN_MAX);
            if (acc)
                level_next = sample;

            case (state_q)
                S_INIT:         if (acc) state_next = level_next ? S_HIGH : S_LOW;
                S_LOW:          state_next = level_next ? S_ROSE : S_LOW;
                S_HIGH, S_ROSE: state_next = level_next ? S_HIGH : S_FELL;
                S_FELL:         state_next = level_next ? S_ROSE : S_LOW;
                default:        state_next = S_INIT;
            endcase

            // ROSE/FELL are never re-entered from themselves, so landing there is the edge.
            evt_next = (state_next == S_ROSE && (mode == M_ANY || mode == M_RISE)) ||
                       (state_next == S_FELL && (mode == M_ANY || mode == M_FALL));
        end

        if (clear_cnt) begin
            cnt_next = CNT_W'(evt_next);
            sat_next = 1'b0;
        end else if (evt_next && cnt != CNT_MAX) begin
            cnt_next = cnt + 1'b1;
            if (cnt_next == CNT_MAX)
                sat_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_prev <= 1'b0;
            run_cnt  <= 4'd0;
            level    <= 1'b0;
            state_q  <= S_INIT;
            evt      <= 1'b0;
            cnt      <= '0;
            sat      <= 1'b0;
        end else begin
            if (valid) begin
                raw_prev <= sample;
                run_cnt  <= run_next;
            end
            level   <= level_next;
            state_q <= state_next;
            evt     <= evt_next;
            cnt     <= cnt_next;
            sat     <= sat_next;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/multi_edge_detector.sv
// NUM_CH independent edge-detector channels with a registered any-event flag
// and flat output buses (channel 0 in the LSBs).
module multi_edge_detector
    import edge_fsm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_RUN = 1,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [NUM_CH-1:0]       in_data,
    input  logic [1:0]              mode,
    input  logic                    clear_cnt,
    output logic [NUM_CH-1:0]       evt,
    output logic                    evt_any,
    output logic [NUM_CH-1:0]       level,
    output logic [3*NUM_CH-1:0]     state_o,
    output logic [CNT_W*NUM_CH-1:0] evt_cnt,
    output logic [NUM_CH-1:0]       cnt_sat
);

    logic [NUM_CH-1:0] evt_pre;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_fsm_channel #(
            .MIN_RUN (MIN_RUN),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .valid     (in_valid),
            .sample    (in_data[i]),
            .mode      (mode),
            .clear_cnt (clear_cnt),
            .evt_next  (evt_pre[i]),
            .evt       (evt[i]),
            .level     (level[i]),
            .state     (state_o[3*i +: 3]),
            .cnt       (evt_cnt[CNT_W*i +: CNT_W]),
            .sat       (cnt_sat[i])
        );
    end

    // Flopped from the per-channel next-event terms so it aligns with evt exactly.
    always_ff @(posedge clk) begin
        if (reset)
            evt_any <= 1'b0;
        else
            evt_any <= |evt_pre;
    end

endmodule
